// File: rtl/and_nbm_qualified.sv
// -----------------------------------------------------------------------------
// and_nbm_qualified
//
// Qualified N-input AND with per-input inversion. Each raw input is
// synchronised, XORed with a run-time reloadable inversion mask and ANDed into
// a registered unqualified match (raw). The match must persist for HOLD
// consecutive enabled cycles before the qualified level (o) asserts. Loss of
// the match drops o on the next enabled edge, with no filtering. rise and fall
// pulse for the first cycle of each new o level. sticky latches any rise until
// it is cleared.
//
// Ports
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   en          qualification enable (counter and o freeze when low)
//   i           raw inputs, WIDTH bits
//   inv_load    load inv_value into the inversion mask
//   inv_value   new inversion mask, WIDTH bits
//   sticky_clr  clear the sticky flag (a simultaneous rise wins)
//   o           qualified match level
//   rise        one-cycle pulse on o 0->1
//   fall        one-cycle pulse on o 1->0
//   sticky      set by rise, held until sticky_clr
//   raw         registered unqualified match
//   mask        current inversion mask
// -----------------------------------------------------------------------------
module and_nbm_qualified #(
    parameter int               WIDTH       = 5,
    parameter logic [WIDTH-1:0] INV_MASK    = 5'b01111,
    parameter int               SYNC_STAGES = 2,
    parameter int               HOLD        = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [WIDTH-1:0] i,
    input  logic             inv_load,
    input  logic [WIDTH-1:0] inv_value,
    input  logic             sticky_clr,
    output logic             o,
    output logic             rise,
    output logic             fall,
    output logic             sticky,
    output logic             raw,
    output logic [WIDTH-1:0] mask
);

    // Counter only needs to reach HOLD-1, where it saturates.
    localparam int             CW      = (HOLD < 2) ? 1 : $clog2(HOLD + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(HOLD - 1);

    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] mask_reg;
    logic             raw_reg;
    logic [CW-1:0]    cnt_reg;
    logic [CW-1:0]    cnt_next;
    logic             o_reg;
    logic             o_next;
    logic             rise_reg;
    logic             fall_reg;
    logic             sticky_reg;

    // -------------------------------------------------------------------------
    // Input synchroniser. With zero stages the raw inputs feed raw_reg
    // directly, so raw_reg is then the only register on the input path.
    // -------------------------------------------------------------------------
    if (SYNC_STAGES == 0) begin : g_nosync
        assign sync_out = i;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_reg;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                stage_reg <= '0;
            end else begin
                stage_reg[0] <= i;
                for (int s = 1; s < SYNC_STAGES; s++) begin
                    stage_reg[s] <= stage_reg[s-1];
                end
            end
        end

        assign sync_out = stage_reg[SYNC_STAGES-1];
    end

    // Per-input match term: mask bit 1 means the input is active-low.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_term
        assign term[gi] = sync_out[gi] ^ mask_reg[gi];
    end

    // -------------------------------------------------------------------------
    // Next-state logic for the hold counter and qualified level.
    // o_next looks at the counter before it increments, so a match seen at raw
    // on HOLD consecutive enabled edges asserts o on the HOLD-th edge.
    // -------------------------------------------------------------------------
    always_comb begin
        cnt_next = '0;
        if (raw_reg) begin
            cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CW'(1);
        end
        o_next = raw_reg && (cnt_reg >= CNT_MAX);
    end

    // -------------------------------------------------------------------------
    // State registers. inv_load overrides en: it restarts qualification from
    // scratch, so o drops (fall reports it if o was high) and rise stays low.
    // raw_reg keeps using the old mask on the load edge itself.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_reg   <= INV_MASK;
            raw_reg    <= 1'b0;
            cnt_reg    <= '0;
            o_reg      <= 1'b0;
            rise_reg   <= 1'b0;
            fall_reg   <= 1'b0;
            sticky_reg <= 1'b0;
        end else begin
            raw_reg    <= &term;
            // Set from the registered rise pulse; set beats a concurrent clear.
            sticky_reg <= rise_reg | (sticky_reg & ~sticky_clr);
            if (inv_load) begin
                mask_reg <= inv_value;
                cnt_reg  <= '0;
                o_reg    <= 1'b0;
                rise_reg <= 1'b0;
                fall_reg <= o_reg;
            end else if (en) begin
                cnt_reg  <= cnt_next;
                o_reg    <= o_next;
                rise_reg <= o_next & ~o_reg;
                fall_reg <= ~o_next & o_reg;
            end else begin
                rise_reg <= 1'b0;
                fall_reg <= 1'b0;
            end
        end
    end

    assign o      = o_reg;
    assign rise   = rise_reg;
    assign fall   = fall_reg;
    assign sticky = sticky_reg;
    assign raw    = raw_reg;
    assign mask   = mask_reg;

endmodule

// File: tb/tb_and_nbm_qualified.sv
// -----------------------------------------------------------------------------
// tb_and_nbm_qualified
//
// Directed bench for and_nbm_qualified at default parameters (WIDTH=5,
// INV_MASK=5'b01111, SYNC_STAGES=2, HOLD=4). Inputs change 1 ns after a rising
// edge and outputs are sampled 1 ns after the next rising edge, so "edge k"
// below is the k-th edge that samples a new input value (counting from 0).
// Expected latencies: raw after edge 2, o rise after edge 6, o fall after
// edge 3.
// -----------------------------------------------------------------------------
module tb_and_nbm_qualified;

    logic       clk;
    logic       reset_n;
    logic       en;
    logic [4:0] i;
    logic       inv_load;
    logic [4:0] inv_value;
    logic       sticky_clr;
    logic       o;
    logic       rise;
    logic       fall;
    logic       sticky;
    logic       raw;
    logic [4:0] mask;

    int n_checks = 0;
    int n_pass   = 0;

    and_nbm_qualified dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .i          (i),
        .inv_load   (inv_load),
        .inv_value  (inv_value),
        .sticky_clr (sticky_clr),
        .o          (o),
        .rise       (rise),
        .fall       (fall),
        .sticky     (sticky),
        .raw        (raw),
        .mask       (mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One table row: inputs applied before an edge, outputs expected after it.
    typedef struct packed {
        logic [4:0] i;
        logic       sclr;
        logic       o;
        logic       rise;
        logic       fall;
        logic       sticky;
        logic       raw;
    } vec_t;

    localparam int NROWS = 23;
    vec_t tbl [NROWS];

    function automatic vec_t mk(logic [4:0] vi, logic sclr, logic eo, logic er,
                                logic ef, logic es, logic eraw);
        mk = {vi, sclr, eo, er, ef, es, eraw};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic eo, input logic er,
                           input logic ef);
        chk({tag, "_o"}, o, eo);
        chk({tag, "_rise"}, rise, er);
        chk({tag, "_fall"}, fall, ef);
    endtask

    initial begin
        // Reset, i=10000 qualifies (rows 0-7); drop it (rows 8-12);
        // a 3-cycle glitch (rows 13-20); sticky clear (rows 21-22).
        //             i         sclr  o     rise  fall  stky  raw
        tbl[0]  = mk(5'b10000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[1]  = mk(5'b10000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[2]  = mk(5'b10000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tbl[3]  = mk(5'b10000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tbl[4]  = mk(5'b10000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tbl[5]  = mk(5'b10000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tbl[6]  = mk(5'b10000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        tbl[7]  = mk(5'b10000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        tbl[8]  = mk(5'b10001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        tbl[9]  = mk(5'b10001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        tbl[10] = mk(5'b10001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[11] = mk(5'b10001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        tbl[12] = mk(5'b10001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[13] = mk(5'b10000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[14] = mk(5'b10000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[15] = mk(5'b10000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tbl[16] = mk(5'b10001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tbl[17] = mk(5'b10001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tbl[18] = mk(5'b10001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[19] = mk(5'b10001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[20] = mk(5'b10001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[21] = mk(5'b10001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[22] = mk(5'b10001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        reset_n    = 1'b0;
        en         = 1'b1;
        i          = 5'b00000;
        inv_load   = 1'b0;
        inv_value  = 5'b00000;
        sticky_clr = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        chk("rst_mask", mask, 5'b01111);
        chk("rst_o", o, 1'b0);
        chk("rst_rise", rise, 1'b0);
        chk("rst_fall", fall, 1'b0);
        chk("rst_sticky", sticky, 1'b0);
        chk("rst_raw", raw, 1'b0);

        // ---------------- table-driven section ----------------
        for (int r = 0; r < NROWS; r++) begin
            i          = tbl[r].i;
            sticky_clr = tbl[r].sclr;
            tick();
            chk($sformatf("row%0d_o", r), o, tbl[r].o);
            chk($sformatf("row%0d_rise", r), rise, tbl[r].rise);
            chk($sformatf("row%0d_fall", r), fall, tbl[r].fall);
            chk($sformatf("row%0d_sticky", r), sticky, tbl[r].sticky);
            chk($sformatf("row%0d_raw", r), raw, tbl[r].raw);
            $display("row %0d: i=%b o=%b rise=%b fall=%b sticky=%b raw=%b",
                     r, i, o, rise, fall, sticky, raw);
        end
        sticky_clr = 1'b0;

        // ---------------- mask reload ----------------
        i = 5'b10000;
        for (int k = 0; k < 7; k++) begin
            tick();
            chk_out($sformatf("reload_pre_e%0d", k), k == 6, k == 6, 1'b0);
        end
        // Load with en low: inv_load still takes effect.
        en        = 1'b0;
        inv_load  = 1'b1;
        inv_value = 5'b00000;
        tick();
        chk_out("reload_load", 1'b0, 1'b0, 1'b1);
        chk("reload_mask", mask, 5'b00000);
        $display("mask reload: mask=%b o=%b fall=%b", mask, o, fall);
        inv_load = 1'b0;
        en       = 1'b1;
        i        = 5'b11111;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk_out($sformatf("reload_post_e%0d", k), k >= 6, k == 6, 1'b0);
        end

        // ---------------- enable freeze + sticky priority ----------------
        sticky_clr = 1'b1;
        i          = 5'b00000;
        tick();
        chk("freeze_sticky_clr", sticky, 1'b0);
        sticky_clr = 1'b0;
        for (int k = 1; k < 5; k++) begin
            tick();
            chk_out($sformatf("freeze_drop_e%0d", k), k < 3, 1'b0, k == 3);
        end
        i = 5'b11111;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("freeze_cnt_e%0d_o", k), o, 1'b0);
        end
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk_out($sformatf("freeze_off_c%0d", k), 1'b0, 1'b0, 1'b0);
        end
        en = 1'b1;
        tick();
        chk_out("freeze_reen_e1", 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("freeze_reen_e2", 1'b1, 1'b1, 1'b0);
        $display("enable freeze: o=%b rise=%b after re-enable", o, rise);
        sticky_clr = 1'b1;
        tick();
        chk("sticky_set_wins", sticky, 1'b1);
        chk("sticky_rise_done", rise, 1'b0);
        tick();
        chk("sticky_cleared", sticky, 1'b0);
        sticky_clr = 1'b0;
        tick();
        chk("saturate_o", o, 1'b1);
        chk("saturate_rise", rise, 1'b0);

        // ---------------- asynchronous reset mid-count ----------------
        i = 5'b00000;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_out($sformatf("areset_drop_e%0d", k), k < 3, 1'b0, k == 3);
        end
        i = 5'b11111;
        for (int k = 0; k < 6; k++) tick();
        chk("areset_pre_o", o, 1'b0);
        chk("areset_pre_raw", raw, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("areset_o", o, 1'b0);
        chk("areset_rise", rise, 1'b0);
        chk("areset_fall", fall, 1'b0);
        chk("areset_sticky", sticky, 1'b0);
        chk("areset_raw", raw, 1'b0);
        chk("areset_mask", mask, 5'b01111);
        $display("async reset: o=%b raw=%b mask=%b", o, raw, mask);
        i = 5'b10000;
        #1;
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk_out($sformatf("areset_post_e%0d", k), k >= 6, k == 6, 1'b0);
            chk($sformatf("areset_post_e%0d_raw", k), raw, k >= 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
